johnson_decoder_monitor: RTL and testbench

- Receive-side companion to the twisted-ring (Johnson) counter.
- Samples a WIDTH-bit Johnson code stream and decodes it to a binary phase index and a one-hot phase.
- Checks code legality and step adjacency, tracks lock, and counts full-cycle wraps.
- Sits on the consumer side of any Johnson-sequenced timing/phase generator in the design.

---
 rtl/johnson_decoder_monitor.sv | 182 ++++++++++++++++++
 tb/tb_johnson_decoder_monitor.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/johnson_decoder_monitor.sv
// rtl/johnson_decoder_monitor.sv - Johnson code decoder with legality, adjacency, lock and wrap tracking
//
// Ports:
//   clk      : rising-edge clock
//   reset    : synchronous active-high reset
//   jc_in    : sampled Johnson code, WIDTH bits
//   jc_valid : jc_in is taken on this edge only when 1
//   phase    : last legal decoded phase, 0..2*WIDTH-1
//   onehot   : one-hot of phase
//   code_err : one-cycle pulse, illegal code sampled
//   step_err : one-cycle pulse, legal code but non-adjacent step
//   locked   : sequence tracking established
//   wrap_cnt : saturating count of N-1 -> 0 steps taken while locked
//   err_cnt  : (only with JD_ERR_CNT_EN) saturating count of error-pulse cycles
//
// Optional macro: JD_ERR_CNT_EN adds the 8-bit err_cnt output.

module johnson_decoder_monitor #(
    parameter int WIDTH      = 4,
    parameter int LOCK_STEPS = 4,
    parameter int WRAP_W     = 8,
    localparam int N         = 2 * WIDTH,
    localparam int PW        = $clog2(N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  jc_in,
    input  logic              jc_valid,
    output logic [PW-1:0]     phase,
    output logic [N-1:0]      onehot,
    output logic              code_err,
    output logic              step_err,
    output logic              locked,
    output logic [WRAP_W-1:0] wrap_cnt
`ifdef JD_ERR_CNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [7:0]        cnt, cnt_n, cnt_inc;
    logic [PW-1:0]     phase_n, phase_inc;
    logic [N-1:0]      onehot_n;
    logic              code_err_n, step_err_n, locked_n;
    logic [WRAP_W-1:0] wrap_n;

    // Decode: a code with bit0 set (or all-zero) is a "filling" state whose
    // ones must sit at the LSB end; otherwise it is a "draining" state whose
    // ones must sit at the MSB end.
    int               pop;
    logic [WIDTH-1:0] low_mask, high_mask;
    logic             dec_legal;
    logic [PW-1:0]    dec_phase;

    always_comb begin
        pop = 0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + int'(jc_in[i]);
        end
        low_mask  = '0;
        high_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            low_mask[i]  = (i < pop);
            high_mask[i] = (i >= WIDTH - pop);
        end
        if (jc_in[0] || (jc_in == '0)) begin
            dec_legal = (jc_in == low_mask);
            dec_phase = PW'(pop);
        end else begin
            dec_legal = (jc_in == high_mask);
            dec_phase = PW'(N - pop);
        end
    end

    assign phase_inc = (phase == PW'(N - 1)) ? '0 : phase + 1'b1;
    assign cnt_inc   = cnt + 8'd1;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        phase_n    = phase;
        code_err_n = 1'b0;
        step_err_n = 1'b0;
        locked_n   = locked;
        wrap_n     = wrap_cnt;

        if (jc_valid) begin
            if (!dec_legal) begin
                code_err_n = 1'b1;
                locked_n   = 1'b0;
                state_n    = UNLOCKED;
                cnt_n      = 8'd0;
            end else begin
                case (state)
                    UNLOCKED: begin
                        phase_n  = dec_phase;
                        state_n  = ACQUIRE;
                        cnt_n    = 8'd0;
                        locked_n = 1'b0;
                    end
                    ACQUIRE: begin
                        if (dec_phase == phase_inc) begin
                            phase_n = dec_phase;
                            cnt_n   = cnt_inc;
                            if (cnt_inc == 8'(LOCK_STEPS)) begin
                                state_n  = LOCKED;
                                locked_n = 1'b1;
                            end
                        end else if (dec_phase != phase) begin
                            // Re-anchor on the new phase and start counting again.
                            step_err_n = 1'b1;
                            phase_n    = dec_phase;
                            cnt_n      = 8'd0;
                        end
                    end
                    LOCKED: begin
                        if (dec_phase == phase_inc) begin
                            phase_n = dec_phase;
                            if ((phase == PW'(N - 1)) && (wrap_cnt != '1)) begin
                                wrap_n = wrap_cnt + 1'b1;
                            end
                        end else if (dec_phase != phase) begin
                            step_err_n = 1'b1;
                            locked_n   = 1'b0;
                            phase_n    = dec_phase;
                            cnt_n      = 8'd0;
                            state_n    = ACQUIRE;
                        end
                    end
                    default: begin
                        state_n  = UNLOCKED;
                        cnt_n    = 8'd0;
                        locked_n = 1'b0;
                    end
                endcase
            end
        end

        onehot_n = {{(N - 1){1'b0}}, 1'b1} << phase_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= UNLOCKED;
            cnt      <= 8'd0;
            phase    <= '0;
            onehot   <= {{(N - 1){1'b0}}, 1'b1};
            code_err <= 1'b0;
            step_err <= 1'b0;
            locked   <= 1'b0;
            wrap_cnt <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            phase    <= phase_n;
            onehot   <= onehot_n;
            code_err <= code_err_n;
            step_err <= step_err_n;
            locked   <= locked_n;
            wrap_cnt <= wrap_n;
        end
    end

`ifdef JD_ERR_CNT_EN
    // Counts in step with the error pulses it is about to register.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt <= 8'd0;
        end else if ((code_err_n || step_err_n) && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_johnson_decoder_monitor.sv
// tb/tb_johnson_decoder_monitor.sv - directed self-checking bench for johnson_decoder_monitor

module tb_johnson_decoder_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] jc_in;
    logic       jc_valid;
    logic [2:0] phase;
    logic [7:0] onehot;
    logic       code_err;
    logic       step_err;
    logic       locked;
    logic [7:0] wrap_cnt;
`ifdef JD_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int passed = 0;
    int total  = 0;
    int failed = 0;

    logic [3:0] code_tab [8];

    johnson_decoder_monitor #(
        .WIDTH(4), .LOCK_STEPS(4), .WRAP_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .jc_in(jc_in),
        .jc_valid(jc_valid),
        .phase(phase),
        .onehot(onehot),
        .code_err(code_err),
        .step_err(step_err),
        .locked(locked),
        .wrap_cnt(wrap_cnt)
`ifdef JD_ERR_CNT_EN
        ,
        .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Apply one sample on the next rising edge, then sample outputs 1 time unit later.
    task automatic drive(input logic [3:0] code, input logic valid);
        jc_in    = code;
        jc_valid = valid;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input string tag, input int ph, input logic ce,
                              input logic se, input logic lk, input int wr);
        logic [7:0] oh;
        oh = 8'd1 << ph;
        chk({tag, ".phase"},    32'(phase),    32'(ph));
        chk({tag, ".onehot"},   32'(onehot),   32'(oh));
        chk({tag, ".code_err"}, 32'(code_err), 32'(ce));
        chk({tag, ".step_err"}, 32'(step_err), 32'(se));
        chk({tag, ".locked"},   32'(locked),   32'(lk));
        chk({tag, ".wrap_cnt"}, 32'(wrap_cnt), 32'(wr));
    endtask

    initial begin
        code_tab = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                     4'b1111, 4'b1110, 4'b1100, 4'b1000};
        reset    = 1'b1;
        jc_in    = 4'b0000;
        jc_valid = 1'b0;

        // Reset state
        drive(4'b0000, 1'b0);
        drive(4'b0000, 1'b0);
        expect_all("reset", 0, 0, 0, 0, 0);
`ifdef JD_ERR_CNT_EN
        chk("reset.err_cnt", 32'(err_cnt), 32'd0);
`endif
        reset = 1'b0;

        // Full sequence from reset: lock after 4th good step (phase 4)
        for (int k = 0; k < 8; k++) begin
            drive(code_tab[k], 1'b1);
            expect_all($sformatf("seq%0d", k), k, 0, 0, (k >= 4), 0);
        end

        // Two wraps while locked
        drive(code_tab[0], 1'b1);
        expect_all("wrap1", 0, 0, 0, 1, 1);
        for (int k = 1; k < 8; k++) drive(code_tab[k], 1'b1);
        expect_all("pre_wrap2", 7, 0, 0, 1, 1);
        drive(code_tab[0], 1'b1);
        expect_all("wrap2", 0, 0, 0, 1, 2);

        // Locked at phase 3, illegal 0101, then re-acquire on 0111
        for (int k = 1; k < 4; k++) drive(code_tab[k], 1'b1);
        expect_all("at3", 3, 0, 0, 1, 2);
        drive(4'b0101, 1'b1);
        expect_all("illegal", 3, 1, 0, 0, 2);
        drive(4'b0111, 1'b1);
        expect_all("reacq", 3, 0, 0, 0, 2);

        // Relock (phases 4..7), wrap to 3, advance to phase 2
        for (int k = 4; k < 8; k++) drive(code_tab[k], 1'b1);
        expect_all("relock7", 7, 0, 0, 1, 2);
        drive(code_tab[0], 1'b1);
        drive(code_tab[1], 1'b1);
        drive(code_tab[2], 1'b1);
        expect_all("at2", 2, 0, 0, 1, 3);

        // Non-adjacent jump 2 -> 6 while locked
        drive(4'b1100, 1'b1);
        expect_all("jump6", 6, 0, 1, 0, 3);
        drive(code_tab[7], 1'b1);
        drive(code_tab[0], 1'b1);
        expect_all("acq_wrap_nocount", 0, 0, 0, 0, 3);
        drive(code_tab[1], 1'b1);
        expect_all("acq3", 1, 0, 0, 0, 3);
        drive(code_tab[2], 1'b1);
        expect_all("acq4_lock", 2, 0, 0, 1, 3);

        // Valid toggling with holds and ignored garbage while locked
        drive(4'b0101, 1'b0);
        expect_all("inv_garbage", 2, 0, 0, 1, 3);
        drive(code_tab[2], 1'b1);
        expect_all("hold_locked", 2, 0, 0, 1, 3);

        // Holds in ACQUIRE do not count; step_err in ACQUIRE restarts count
        drive(4'b1010, 1'b1);
        expect_all("illegal2", 2, 1, 0, 0, 3);
        drive(code_tab[2], 1'b1);
        expect_all("load2", 2, 0, 0, 0, 3);
        drive(code_tab[4], 1'b1);
        expect_all("acq_jump4", 4, 0, 1, 0, 3);
        drive(code_tab[4], 1'b1);
        drive(4'b0101, 1'b0);
        drive(code_tab[4], 1'b1);
        expect_all("acq_holds", 4, 0, 0, 0, 3);
        drive(code_tab[5], 1'b1);
        drive(4'b1111, 1'b0);
        drive(code_tab[6], 1'b1);
        drive(code_tab[7], 1'b1);
        expect_all("acq_three", 7, 0, 0, 0, 3);
        drive(code_tab[0], 1'b1);
        expect_all("acq_fourth", 0, 0, 0, 1, 3);

        // Reset wins over a valid sample
        reset = 1'b1;
        drive(code_tab[1], 1'b1);
        expect_all("reset_mid", 0, 0, 0, 0, 0);
`ifdef JD_ERR_CNT_EN
        chk("reset_mid.err_cnt", 32'(err_cnt), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 300; i++) drive((i % 2 == 0) ? 4'b0101 : 4'b1010, 1'b1);
        chk("err_cnt_sat", 32'(err_cnt), 32'd255);
        chk("err_cnt_code_err", 32'(code_err), 32'd1);
`endif
        reset = 1'b0;
        drive(code_tab[0], 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
